// File: rtl/ysyx_load_unit.sv
// Load unit: one load at a time, word-aligned AR/R read, byte/half/word extract with sign/zero extension.
// Latency: request accepted at edge 0 -> arvalid cycle 1, rready cycle 2, wb_valid cycle 3 (error short path: cycle 1).
// Backpressure: req_ready only in IDLE; arvalid, wb_valid and their payloads are held until the handshake completes.
module ysyx_load_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_rd_sel,
    input  logic [4:0]        req_rd,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_err,
    output logic [31:0]       ld_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_WB   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        sel_q;
    logic [4:0]        rd_q;
    logic [31:0]       data_q;
    logic              err_q;
    logic [31:0]       cnt_q;

    logic req_fire;
    logic req_bad;
    logic r_fire;
    logic wb_fire;

    // Illegal funct3 codes and misaligned halfword/word accesses never reach memory.
    function automatic logic ld_bad(input logic [2:0] sel, input logic [1:0] a);
        case (sel)
            3'b000, 3'b100: ld_bad = 1'b0;
            3'b001, 3'b101: ld_bad = a[0];
            3'b010:         ld_bad = (a != 2'b00);
            default:        ld_bad = 1'b1;
        endcase
    endfunction

    // Select the addressed lane of the read word and extend it to 32 bits.
    function automatic logic [31:0] ld_extract(input logic [2:0] sel, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = w[16*a[1] +: 16];
        case (sel)
            3'b000:  ld_extract = {{24{b[7]}}, b};
            3'b001:  ld_extract = {{16{h[15]}}, h};
            3'b100:  ld_extract = {24'd0, b};
            3'b101:  ld_extract = {16'd0, h};
            default: ld_extract = w;
        endcase
    endfunction

    assign req_fire = req_valid && (state_q == S_IDLE);
    assign req_bad  = ld_bad(req_rd_sel, req_addr[1:0]);
    assign r_fire   = mem_rvalid && (state_q == S_R);
    assign wb_fire  = wb_ready && (state_q == S_WB);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: errors detected at accept skip straight to writeback.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid)   state_d = req_bad ? S_WB : S_AR;
            S_AR:   if (mem_arready) state_d = S_R;
            S_R:    if (mem_rvalid)  state_d = S_WB;
            S_WB:   if (wb_ready)    state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so no input reaches an output combinationally.
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        mem_arvalid = (state_q == S_AR);
        mem_rready  = (state_q == S_R);
        wb_valid    = (state_q == S_WB);
    end

    // Request fields, result and error; held unchanged while waiting on AR/R/WB handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            sel_q  <= 3'd0;
            rd_q   <= 5'd0;
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else if (req_fire) begin
            addr_q <= req_addr;
            sel_q  <= req_rd_sel;
            rd_q   <= req_rd;
            data_q <= 32'd0;
            err_q  <= req_bad;
        end else if (r_fire) begin
            data_q <= (mem_rresp != 2'b00) ? 32'd0 : ld_extract(sel_q, addr_q[1:0], mem_rdata[31:0]);
            err_q  <= (mem_rresp != 2'b00);
        end
    end

    // Completed-load counter; error completions count too, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= 32'd0;
        else if (wb_fire) cnt_q <= cnt_q + 32'd1;
    end

    assign mem_araddr = {addr_q[ADDR_W-1:2], 2'b00};
    assign wb_data    = data_q;
    assign wb_rd      = rd_q;
    assign wb_err     = err_q;
    assign ld_cnt     = cnt_q;

endmodule

// File: tb/tb_ysyx_load_unit.sv
module tb_ysyx_load_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_rd_sel;
    logic [4:0]  req_rd;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_err;
    logic [31:0] ld_cnt;

    int tests;
    int fails;
    int exp_cnt;

    ysyx_load_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rd_sel(req_rd_sel), .req_rd(req_rd),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_err(wb_err), .ld_cnt(ld_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what a RISC-V load returns, from access size, alignment and sign rules.
    function automatic void model(input logic [31:0] a, input logic [2:0] s, input logic [31:0] w,
                                  input logic [1:0] resp, output logic [31:0] d, output logic e,
                                  output logic short_path);
        longint unsigned size;
        longint unsigned v;
        longint unsigned bits;
        bit legal;
        legal = (s == 3'd0) || (s == 3'd1) || (s == 3'd2) || (s == 3'd4) || (s == 3'd5);
        size  = (s == 3'd0 || s == 3'd4) ? 1 : ((s == 3'd1 || s == 3'd5) ? 2 : 4);
        short_path = !legal || ((longint'(a) % size) != 0);
        if (short_path || resp != 2'b00) begin
            d = 32'd0;
            e = 1'b1;
        end else begin
            bits = size * 8;
            v = (longint'(w) >> ((longint'(a) % 4) * 8)) % (64'd1 << bits);
            if (s == 3'd0 || s == 3'd1) begin
                if (v >= (64'd1 << (bits - 1))) v = v + 64'hFFFF_FFFF_0000_0000 - (64'd1 << bits) + 64'h1_0000_0000;
            end
            d = 32'(v);
            e = 1'b0;
        end
    endfunction

    // One full load: drives request, plays memory and writeback, checks every cycle.
    task automatic do_load(input logic [31:0] a, input logic [2:0] s, input logic [4:0] rd,
                           input logic [31:0] rdat, input logic [1:0] resp,
                           input int arw, input int rw, input int wbw);
        logic [31:0] ed;
        logic ee, es;
        model(a, s, rdat, resp, ed, ee, es);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL req_ready_idle: got %b want 1", req_ready); end
        req_valid = 1'b1; req_addr = a; req_rd_sel = s; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_rd_sel = 3'($urandom); req_rd = 5'($urandom);
        if (es) begin
            tests++; if (mem_arvalid !== 1'b0) begin fails++; $display("FAIL short_no_arvalid: got %b want 0", mem_arvalid); end
        end else begin
            for (int i = 0; i <= arw; i++) begin
                tests++; if (mem_arvalid !== 1'b1) begin fails++; $display("FAIL arvalid: got %b want 1", mem_arvalid); end
                tests++; if (mem_araddr !== {a[31:2], 2'b00}) begin fails++; $display("FAIL araddr: got %h want %h", mem_araddr, {a[31:2], 2'b00}); end
                tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL req_ready_ar: got %b want 0", req_ready); end
                mem_arready = (i == arw);
                mem_rvalid = 1'b1; mem_rdata = ~rdat; mem_rresp = 2'b00;
                @(negedge clk);
            end
            mem_arready = 1'b0;
            for (int i = 0; i <= rw; i++) begin
                tests++; if (mem_rready !== 1'b1) begin fails++; $display("FAIL rready: got %b want 1", mem_rready); end
                tests++; if ({mem_arvalid, wb_valid, req_ready} !== 3'b000) begin fails++; $display("FAIL r_state_outs: got %b want 000", {mem_arvalid, wb_valid, req_ready}); end
                mem_rvalid = (i == rw);
                mem_rdata  = (i == rw) ? rdat : ~rdat;
                mem_rresp  = (i == rw) ? resp : 2'b11;
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
        end
        for (int i = 0; i <= wbw; i++) begin
            tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL wb_valid: got %b want 1", wb_valid); end
            tests++; if (wb_data !== ed) begin fails++; $display("FAIL wb_data: got %h want %h (addr %h sel %0d)", wb_data, ed, a, s); end
            tests++; if (wb_rd !== rd) begin fails++; $display("FAIL wb_rd: got %0d want %0d", wb_rd, rd); end
            tests++; if (wb_err !== ee) begin fails++; $display("FAIL wb_err: got %b want %b", wb_err, ee); end
            tests++; if ({req_ready, mem_arvalid, mem_rready} !== 3'b000) begin fails++; $display("FAIL wb_state_outs: got %b want 000", {req_ready, mem_arvalid, mem_rready}); end
            wb_ready = (i == wbw);
            @(negedge clk);
        end
        wb_ready = 1'b0;
        exp_cnt++;
        tests++; if (ld_cnt !== 32'(exp_cnt)) begin fails++; $display("FAIL ld_cnt: got %0d want %0d", ld_cnt, exp_cnt); end
        tests++; if ({req_ready, wb_valid} !== 2'b10) begin fails++; $display("FAIL back_to_idle: got %b want 10", {req_ready, wb_valid}); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++; if ({req_ready, mem_arvalid, mem_rready, wb_valid, wb_err} !== 5'b10000) begin fails++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready, mem_arvalid, mem_rready, wb_valid, wb_err}); end
        tests++; if ({wb_data, mem_araddr, ld_cnt} !== 96'd0) begin fails++; $display("FAIL reset_data: got %h %h %h want 0", wb_data, mem_araddr, ld_cnt); end
        tests++; if (wb_rd !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d want 0", wb_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_lw();
        do_load(32'h8000_0004, 3'b010, 5'd5, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    endtask

    task automatic test_byte();
        do_load(32'h8000_0003, 3'b000, 5'd1, 32'h8011_2233, 2'b00, 0, 0, 0);
        do_load(32'h8000_0003, 3'b100, 5'd2, 32'h8011_2233, 2'b00, 0, 0, 0);
        do_load(32'h8000_0000, 3'b000, 5'd3, 32'h8011_2233, 2'b00, 0, 0, 0);
    endtask

    task automatic test_half();
        do_load(32'h8000_0002, 3'b001, 5'd4, 32'h8001_7FFF, 2'b00, 0, 0, 0);
        do_load(32'h8000_0002, 3'b101, 5'd6, 32'h8001_7FFF, 2'b00, 0, 0, 0);
        do_load(32'h8000_0000, 3'b001, 5'd7, 32'h8001_7FFF, 2'b00, 0, 0, 0);
    endtask

    task automatic test_errors();
        do_load(32'h8000_0002, 3'b010, 5'd8, 32'h1234_5678, 2'b00, 0, 0, 0);
        do_load(32'h8000_0000, 3'b011, 5'd9, 32'h1234_5678, 2'b00, 0, 0, 0);
        do_load(32'h8000_0001, 3'b101, 5'd10, 32'h1234_5678, 2'b00, 0, 0, 0);
        do_load(32'h8000_0008, 3'b010, 5'd11, 32'h1234_5678, 2'b10, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        do_load(32'h8000_0010, 3'b010, 5'd12, 32'hCAFE_F00D, 2'b00, 3, 1, 2);
        do_load(32'h8000_0011, 3'b000, 5'd13, 32'hCAFE_F0FF, 2'b00, 2, 2, 3);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 32'h8000_0020; req_rd_sel = 3'b010; req_rd = 5'd14;
        @(negedge clk);
        req_valid = 1'b0;
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        tests++; if (mem_rready !== 1'b1) begin fails++; $display("FAIL mid_in_r: got %b want 1", mem_rready); end
        rst_n = 1'b0;
        #1;
        tests++; if ({req_ready, mem_arvalid, mem_rready, wb_valid, wb_err} !== 5'b10000) begin fails++; $display("FAIL mid_reset_ctrl: got %b want 10000", {req_ready, mem_arvalid, mem_rready, wb_valid, wb_err}); end
        tests++; if ({wb_data, mem_araddr, ld_cnt, 27'd0, wb_rd} !== 128'd0) begin fails++; $display("FAIL mid_reset_data: got %h %h %h %0d want 0", wb_data, mem_araddr, ld_cnt, wb_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA; mem_rresp = 2'b00;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        tests++; if ({wb_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL mid_rvalid_ignored: got %b want 01", {wb_valid, req_ready}); end
        tests++; if (ld_cnt !== 32'd0) begin fails++; $display("FAIL mid_cnt: got %0d want 0", ld_cnt); end
        do_load(32'h8000_0024, 3'b010, 5'd15, 32'h0BAD_CAFE, 2'b00, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [2:0] sels [8];
        sels = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b111};
        for (int n = 0; n < 60; n++) begin
            do_load($urandom, sels[$urandom_range(0, 7)], 5'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        tests = 0; fails = 0; exp_cnt = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_rd_sel = 3'd0; req_rd = 5'd0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_rresp = 2'b00; wb_ready = 1'b0;
        test_reset();
        test_lw();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_load_unit.md
# ysyx_load_unit

Load side of the data-memory path: takes one load request from the execute stage (byte address, `rd_sel` width/sign code, destination register), issues a word-aligned read on a valid/ready memory read channel, and extracts and sign- or zero-extends the addressed byte/halfword/word. It returns the result to writeback through a valid/ready handshake. It is the read counterpart of the store path (word write with byte mask) and sits between the EXU address computation and the register-file write port.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, memory data width; only 32 is supported
- `clk` input 1 — clock, rising edge
- `rst_n` input 1 — reset, asynchronous, active-low
- `req_valid` input 1 — load request valid
- `req_ready` output 1 — unit can accept a request
- `req_addr` input ADDR_W — byte address (ALU result)
- `req_rd_sel` input 3 — RISC-V funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- `req_rd` input 5 — destination register index
- `mem_arvalid` output 1 — read address valid
- `mem_arready` input 1 — memory accepts address
- `mem_araddr` output ADDR_W — `{req_addr[ADDR_W-1:2], 2'b00}`
- `mem_rvalid` input 1 — read data valid
- `mem_rready` output 1 — unit accepts read data
- `mem_rdata` input 32 — read word
- `mem_rresp` input 2 — 00 OK, any other value is an error
- `wb_valid` output 1 — result valid
- `wb_ready` input 1 — writeback accepts result
- `wb_data` output 32 — extended load data
- `wb_rd` output 5 — destination register
- `wb_err` output 1 — misaligned, illegal `rd_sel`, or bus error
- `ld_cnt` output 32 — completed-load counter

## Operation
- FSM states: IDLE, AR, R, WB.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch addr, rd_sel, rd. Then:
  - misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]≠0) or illegal rd_sel → WB with err=1, data=0;
  - otherwise → AR.
- AR: `mem_arvalid`=1, `mem_araddr` held stable. On `mem_arready` → R. arvalid is never withdrawn before arready.
- R: `mem_rready`=1. On `mem_rvalid`:
  - rresp≠0 → data=0, err=1;
  - otherwise → data is extracted from `mem_rdata` and err=0.
  - Then → WB.
- Extraction:
  - byte = `rdata[8*addr[1:0] +: 8]`;
  - half = `rdata[16*addr[1] +: 16]`;
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- WB: `wb_valid`=1; `wb_data`, `wb_rd`, `wb_err` held stable. On `wb_ready` → IDLE, and `ld_cnt` increments by 1, including error completions. `ld_cnt` wraps 0xFFFFFFFF→0.
- One outstanding request at a time. No request bypass: `req_ready` is 0 in AR, R and WB.
- `mem_rvalid` is ignored outside R. `mem_arready` is ignored outside AR.

## Timing
- Reset (async assert, sync deassert is the integrator's responsibility):
  - state=IDLE;
  - `req_ready`=1;
  - `mem_arvalid`=`mem_rready`=`wb_valid`=`wb_err`=0;
  - `wb_data`=0, `wb_rd`=0, `mem_araddr`=0, `ld_cnt`=0.
- Reset mid-operation: outputs return to reset values immediately. The pending transaction is dropped and produces no writeback. Memory is reset by the same `rst_n`.
- Latency with zero-wait memory and `wb_ready`=1, request accepted at edge 0:
  - `mem_arvalid` high in cycle 1;
  - `mem_rready` high in cycle 2 (rvalid in cycle 2);
  - `wb_valid` high in cycle 3;
  - `req_ready` high again in cycle 4.
- Minimum throughput: one load per 4 cycles.
- Error short-path: `wb_valid` high in cycle 1, no memory traffic.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- LW addr 0x80000004, rdata 0xDEADBEEF, rd=5 → araddr 0x80000004; wb_data 0xDEADBEEF, wb_rd 5, err 0; wb_valid in cycle 3; ld_cnt=1.
- rdata 0x80112233:
  - LB addr 0x80000003 → 0xFFFFFF80;
  - LBU same addr → 0x00000080;
  - LB addr 0x80000000 → 0x00000033.
  - araddr is 0x80000000 in all three cases.
- rdata 0x80017FFF:
  - LH addr+2 → 0xFFFF8001;
  - LHU addr+2 → 0x00008001;
  - LH addr+0 → 0x00007FFF.
- Error cases:
  - LW addr 0x80000002 → no arvalid, wb_valid in cycle 1, err=1, data 0;
  - rd_sel=011 → same response;
  - rresp=2'b10 on an aligned LW → err=1, data 0, ld_cnt increments.
- Backpressure: arready low 3 cycles and wb_ready low 2 cycles → araddr, wb_data, wb_rd stable throughout; req_ready stays 0; exactly one ld_cnt increment.
- rst_n pulsed low during R → all outputs at reset values in the same cycle; later rvalid ignored; next LW completes normally with ld_cnt=1.
